sort_result_serializer: RTL and testbench

//  Consumer end of the 32-lane datasort interface. Captures one parallel sorted frame on
//  vld_in (the sorter's vld_out) and streams it out one element per beat on a valid/ready port.

---
 rtl/sort_pkg.sv | 20 ++
 rtl/sort_order_checker.sv | 41 ++++
 rtl/sort_result_serializer.sv | 100 ++++++++++
 tb/tb_sort_result_serializer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared definitions for the datasort interface: default sizes, the serializer
// state encoding and the pairwise ordering rule.
package sort_pkg;

    localparam int SORT_DATA_W = 8;
    localparam int SORT_N_ELEM = 32;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Unsigned ordering of two neighbours; equal values are always legal.
    function automatic logic pair_ok(input logic ascend,
                                     input logic [31:0] prev,
                                     input logic [31:0] cur);
        return ascend ? (cur >= prev) : (cur <= prev);
    endfunction

endpackage

// File: rtl/sort_order_checker.sv
// Tracks the previously accepted beat and raises a sticky error when a frame
// leaves monotonic order. ok already accounts for the beat presented this cycle.
module sort_order_checker
    import sort_pkg::*;
#(
    parameter int DATA_W = SORT_DATA_W,
    parameter bit ASCEND = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              beat,
    input  logic [DATA_W-1:0] data,
    output logic              ok
);

    logic [DATA_W-1:0] prev;
    logic              first;
    logic              err;
    logic              viol;

    assign viol = beat & ~first & ~pair_ok(ASCEND, 32'(prev), 32'(data));
    assign ok   = ~(err | viol);

    // A start in the same cycle as the old frame's final beat wins: the new frame begins clean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev  <= '0;
            first <= 1'b1;
            err   <= 1'b0;
        end else if (start) begin
            first <= 1'b1;
            err   <= 1'b0;
        end else if (beat) begin
            prev  <= data;
            first <= 1'b0;
            err   <= err | viol;
        end
    end

endmodule

// File: rtl/sort_result_serializer.sv
// Captures one parallel sorted frame and streams it out one element per beat on a
// valid/ready port, reporting per-frame order status and counting dropped frames.
module sort_result_serializer
    import sort_pkg::*;
#(
    parameter int DATA_W = SORT_DATA_W,
    parameter int N_ELEM = SORT_N_ELEM,
    parameter bit ASCEND = 1'b1,
    parameter int IDX_W  = $clog2(N_ELEM)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     vld_in,
    input  logic [N_ELEM*DATA_W-1:0] din_flat,
    output logic                     busy,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DATA_W-1:0]        m_data,
    output logic                     m_last,
    output logic                     frame_done,
    output logic                     order_ok,
    output logic                     drop_err,
    output logic [7:0]               drop_cnt
);

    logic [DATA_W-1:0] frame_buf [N_ELEM];
    logic [IDX_W-1:0]  idx;
    state_t            state;
    state_t            state_nxt;
    logic              handshake;
    logic              last_hs;
    logic              accept;
    logic              drop;
    logic              chk_ok;

    assign m_valid   = (state == SEND);
    assign m_last    = m_valid && (idx == IDX_W'(N_ELEM - 1));
    assign m_data    = m_valid ? frame_buf[idx] : '0;
    assign handshake = m_valid & m_ready;
    assign last_hs   = handshake & m_last;

    // Releasing busy during the final handshake lets the next frame follow with no bubble.
    assign busy   = m_valid & ~(m_last & m_ready);
    assign accept = vld_in & ~busy;
    assign drop   = vld_in & busy;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SEND;
            SEND:    if (last_hs && !accept) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            frame_done <= 1'b0;
            order_ok   <= 1'b0;
            drop_err   <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            frame_done <= last_hs;
            order_ok   <= last_hs & chk_ok;
            drop_err   <= drop;
            if (accept) begin
                idx <= '0;
            end else if (handshake) begin
                idx <= m_last ? '0 : idx + 1'b1;
            end
            if (drop && drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_ELEM; k++) frame_buf[k] <= '0;
        end else if (accept) begin
            for (int k = 0; k < N_ELEM; k++) frame_buf[k] <= din_flat[k*DATA_W +: DATA_W];
        end
    end

    sort_order_checker #(
        .DATA_W (DATA_W),
        .ASCEND (ASCEND)
    ) u_checker (
        .clk   (clk),
        .rst_n (rst_n),
        .start (accept),
        .beat  (handshake),
        .data  (m_data),
        .ok    (chk_ok)
    );

endmodule

// File: tb/tb_sort_result_serializer.sv
// Directed bench for sort_result_serializer: expected beats and frame results are queued
// when a frame is driven and checked as the serial port hands them over.
module tb_sort_result_serializer;

    localparam int DATA_W = 8;
    localparam int N_ELEM = 32;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     vld_in;
    logic [N_ELEM*DATA_W-1:0] din_flat;
    logic                     busy;
    logic                     m_valid;
    logic                     m_ready;
    logic [DATA_W-1:0]        m_data;
    logic                     m_last;
    logic                     frame_done;
    logic                     order_ok;
    logic                     drop_err;
    logic [7:0]               drop_cnt;

    sort_result_serializer #(
        .DATA_W (DATA_W),
        .N_ELEM (N_ELEM),
        .ASCEND (1'b1),
        .IDX_W  (5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vld_in     (vld_in),
        .din_flat   (din_flat),
        .busy       (busy),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .frame_done (frame_done),
        .order_ok   (order_ok),
        .drop_err   (drop_err),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    beat_t       exp_q [$];
    bit          ok_q [$];
    int          n_assert = 0;
    int          n_fail   = 0;
    int          exp_drop = 0;
    bit          stalled  = 1'b0;
    logic [7:0]  held;
    logic [7:0]  lanes [N_ELEM];
    int          raw [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check whatever the port presents this cycle, then advance to 1 time unit after the next edge.
    task automatic step();
        beat_t b;
        bit    ok_exp;
        if (stalled && m_valid) chk("stall_stable", 32'(m_data), 32'(held));
        if (m_valid && m_ready) begin
            chk("beat_pending", 32'(exp_q.size() > 0), 32'(1));
            if (exp_q.size() > 0) begin
                b = exp_q.pop_front();
                chk("beat_data", 32'(m_data), 32'(b.data));
                chk("beat_last", 32'(m_last), 32'(b.last));
            end
        end
        if (frame_done) begin
            chk("frame_done_pending", 32'(ok_q.size() > 0), 32'(1));
            if (ok_q.size() > 0) begin
                ok_exp = ok_q.pop_front();
                chk("order_ok", 32'(order_ok), 32'(ok_exp));
            end
        end
        stalled = m_valid && !m_ready;
        held    = m_data;
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input bit accept);
        bit ok_m;
        for (int k = 0; k < N_ELEM; k++) din_flat[k*DATA_W +: DATA_W] = lanes[k];
        vld_in = 1'b1;
        if (accept) begin
            ok_m = 1'b1;
            for (int k = 0; k < N_ELEM; k++) begin
                exp_q.push_back('{data: lanes[k], last: (k == N_ELEM - 1)});
                if (k > 0 && lanes[k] < lanes[k-1]) ok_m = 1'b0;
            end
            ok_q.push_back(ok_m);
        end
        step();
        vld_in = 1'b0;
    endtask

    task automatic finish_frame(input bit toggle, input int exp_cycles);
        int cyc = 0;
        while ((exp_q.size() > 0 || ok_q.size() > 0) && cyc < 200) begin
            m_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            step();
            cyc++;
        end
        chk("frame_timeout", 32'(cyc < 200), 32'(1));
        if (exp_cycles > 0) chk("frame_cycles", 32'(cyc), 32'(exp_cycles));
        m_ready = 1'b1;
    endtask

    task automatic load_sorted();
        raw = {31, 29, 27, 25, 23, 21, 19, 17, 15, 13, 11, 9, 7, 5, 3, 1,
               2, 2, 4, 4, 4, 4, 8, 16, 8, 16, 32, 32, 0, 10, 20, 30};
        raw.sort();
        for (int k = 0; k < N_ELEM; k++) lanes[k] = 8'(raw[k]);
    endtask

    task automatic load_unsorted();
        for (int k = 0; k < N_ELEM; k++) lanes[k] = 8'(2 * k);
        lanes[5] = 8'd9;
        lanes[6] = 8'd3;
    endtask

    initial begin
        int guard;
        rst_n    = 1'b0;
        vld_in   = 1'b0;
        m_ready  = 1'b0;
        din_flat = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_m_valid", 32'(m_valid), 32'(0));
        chk("rst_m_last", 32'(m_last), 32'(0));
        chk("rst_m_data", 32'(m_data), 32'(0));
        chk("rst_frame_done", 32'(frame_done), 32'(0));
        chk("rst_order_ok", 32'(order_ok), 32'(0));
        chk("rst_drop_err", 32'(drop_err), 32'(0));
        chk("rst_drop_cnt", 32'(drop_cnt), 32'(0));
        rst_n = 1'b1;
        step();

        // Sorted frame at full rate.
        load_sorted();
        m_ready = 1'b1;
        capture(1'b1);
        chk("latency_valid", 32'(m_valid), 32'(1));
        chk("first_beat", 32'(m_data), 32'(0));
        finish_frame(1'b0, 33);

        // Same frame with the sink ready every other cycle.
        capture(1'b1);
        finish_frame(1'b1, 64);

        // Out-of-order frame is still emitted in full but flagged.
        load_unsorted();
        capture(1'b1);
        finish_frame(1'b0, 33);

        // Drops while a frame is in flight, then saturate the drop counter.
        load_sorted();
        capture(1'b1);
        repeat (10) step();
        for (int k = 0; k < N_ELEM; k++) lanes[k] = 8'(200 - k);
        capture(1'b0);
        exp_drop = 1;
        chk("drop_err_pulse", 32'(drop_err), 32'(1));
        chk("drop_cnt_one", 32'(drop_cnt), 32'(exp_drop));
        m_ready = 1'b0;
        step();
        chk("drop_err_clear", 32'(drop_err), 32'(0));
        vld_in = 1'b1;
        repeat (300) begin
            step();
            exp_drop = (exp_drop < 255) ? exp_drop + 1 : 255;
        end
        vld_in = 1'b0;
        step();
        chk("drop_cnt_sat", 32'(drop_cnt), 32'(exp_drop));
        finish_frame(1'b0, 0);
        chk("drop_cnt_hold", 32'(drop_cnt), 32'(8'hFF));

        // Back-to-back: next frame strobed during the final handshake.
        load_sorted();
        capture(1'b1);
        guard = 0;
        while (exp_q.size() > 1 && guard < 100) begin
            step();
            guard++;
        end
        chk("b2b_reach_last", 32'(exp_q.size()), 32'(1));
        load_unsorted();
        capture(1'b1);
        chk("b2b_valid", 32'(m_valid), 32'(1));
        chk("b2b_beat0", 32'(m_data), 32'(lanes[0]));
        finish_frame(1'b0, 33);

        // Reset in the middle of a frame discards it silently.
        load_sorted();
        capture(1'b1);
        repeat (12) step();
        chk("pre_rst_beat12", 32'(m_data), 32'(exp_q[0].data));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(m_valid), 32'(0));
        chk("mid_rst_busy", 32'(busy), 32'(0));
        exp_q.delete();
        ok_q.delete();
        stalled = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("mid_rst_no_done", 32'(frame_done), 32'(0));
        chk("mid_rst_drop_cnt", 32'(drop_cnt), 32'(0));
        load_unsorted();
        capture(1'b1);
        chk("restart_beat0", 32'(m_data), 32'(lanes[0]));
        finish_frame(1'b0, 33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
